// File: rtl/quiz_round_ctrl_pkg.sv
// quiz_pkg: shared types and score helpers for the quiz round sequencer.
// State encoding is visible on the display State output, so values are fixed.
package quiz_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      ANSWER  = 3'd2,
      JUDGE   = 3'd3,
      TIMEOUT = 3'd4
   } state_t;

   localparam int NUM_PLAYERS = 4;

   // Add points to a score, clamping at max_v instead of wrapping.
   function automatic int score_sat_add(input int score, input int pts, input int max_v);
      int sum;
      sum = score + pts;
      return (sum > max_v) ? max_v : sum;
   endfunction

   // Take one point off a score, never going below zero.
   function automatic int score_floor_sub(input int score);
      return (score > 0) ? score - 1 : 0;
   endfunction

endpackage

// File: rtl/quiz_round_ctrl_if.sv
// Host/selection-stage bus of the quiz round sequencer.
// master = host side (drives pulses and selection status), slave = sequencer.
interface quiz_round_ctrl_if
   import quiz_pkg::*;
#(
   parameter int SCORE_W = 4
);
   logic                             Host_Start;
   logic                             Judge_Right;
   logic                             Judge_Wrong;
   logic                             Sel_Locked;
   logic [3:0]                       Sel_Player;
   logic                             Sel_Start;
   logic                             TimeOver_Block;
   logic [7:0]                       Countdown;
   logic [2:0]                       State;
   logic [NUM_PLAYERS*SCORE_W-1:0]   Scores;
   logic                             Round_Done;

   modport master (
      output Host_Start, Judge_Right, Judge_Wrong, Sel_Locked, Sel_Player,
      input  Sel_Start, TimeOver_Block, Countdown, State, Scores, Round_Done
   );

   modport slave (
      input  Host_Start, Judge_Right, Judge_Wrong, Sel_Locked, Sel_Player,
      output Sel_Start, TimeOver_Block, Countdown, State, Scores, Round_Done
   );
endinterface

// File: rtl/quiz_round_ctrl_tick_gen.sv
// quiz_tick_gen: countdown prescaler. Counts 0..TICK_DIV-1 and flags the last
// count as a one-cycle tick. clr_i restarts the count so that the first tick
// after a clear arrives exactly TICK_DIV cycles later.
module quiz_tick_gen #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   output logic tick_o
);
   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;

   // Next count: clear wins, otherwise wrap at the last count.
   always_comb begin
      count_d = count_q + 1'b1;
      if (clr_i || count_q == LAST) begin
         count_d = '0;
      end
   end

   // Prescaler register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tick_o = (count_q == LAST);
endmodule

// File: rtl/quiz_round_ctrl.sv
// quiz_round_ctrl: round sequencer for the quiz responder.
// Releases the selection stage, runs buzz-in and answer countdowns from the
// prescaler tick, takes the host verdict and keeps saturating scores.
// Optional build macro QUIZ_PENALTY_EN: wrong verdict / answer timeout costs
// the locked player one point (floored at 0); otherwise no score change.
module quiz_round_ctrl
   import quiz_pkg::*;
#(
   parameter int TICK_DIV  = 50_000_000,
   parameter int BUZZ_SEC  = 10,
   parameter int ANS_SEC   = 5,
   parameter int SCORE_W   = 4,
   parameter int RIGHT_PTS = 1
) (
   input  logic             CLK,
   input  logic             RSTn,
   quiz_round_ctrl_if.slave bus
);
   localparam int SCORE_MAX = (1 << SCORE_W) - 1;

   state_t                  state_q, state_d;
   logic [7:0]              countdown_q, countdown_d;
   logic [1:0]              player_q, player_d;
   logic                    right_q, right_d;
   logic [SCORE_W-1:0]      score_q [NUM_PLAYERS];
   logic [SCORE_W-1:0]      score_d [NUM_PLAYERS];
   logic                    sel_start_q, block_q, round_done_q;
   logic                    tick, tick_clr, lock_valid;
   logic [NUM_PLAYERS*SCORE_W-1:0] scores_packed;

   // A lock only counts when it names a real player.
   assign lock_valid = bus.Sel_Locked &&
                       (bus.Sel_Player >= 4'd1) &&
                       (bus.Sel_Player <= 4'(NUM_PLAYERS));

   // Every state change restarts the prescaler.
   assign tick_clr = (state_d != state_q);

   quiz_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_i  (CLK),
      .rst_ni (RSTn),
      .clr_i  (tick_clr),
      .tick_o (tick)
   );

   // Next-state, countdown, latched player and verdict.
   always_comb begin
      state_d     = state_q;
      countdown_d = countdown_q;
      player_d    = player_q;
      right_d     = right_q;
      case (state_q)
         IDLE: begin
            if (bus.Host_Start) begin
               state_d     = ARMED;
               countdown_d = 8'(BUZZ_SEC);
            end
         end
         ARMED: begin
            // A lock beats a tick arriving in the same cycle.
            if (lock_valid) begin
               state_d     = ANSWER;
               countdown_d = 8'(ANS_SEC);
               player_d    = 2'(bus.Sel_Player - 4'd1);
            end else if (countdown_q == 8'd0) begin
               state_d = TIMEOUT;
            end else if (tick) begin
               countdown_d = countdown_q - 8'd1;
               if (countdown_q == 8'd1) begin
                  state_d = TIMEOUT;
               end
            end
         end
         ANSWER: begin
            // Right wins over Wrong; any verdict beats the clock.
            if (bus.Judge_Right) begin
               state_d = JUDGE;
               right_d = 1'b1;
            end else if (bus.Judge_Wrong || countdown_q == 8'd0) begin
               state_d = JUDGE;
               right_d = 1'b0;
            end else if (tick) begin
               countdown_d = countdown_q - 8'd1;
               if (countdown_q == 8'd1) begin
                  state_d = JUDGE;
                  right_d = 1'b0;
               end
            end
         end
         JUDGE: begin
            state_d = IDLE;
         end
         TIMEOUT: begin
            countdown_d = 8'd0;
            if (bus.Host_Start) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Score update, applied on the JUDGE cycle to the latched player only.
   always_comb begin
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         score_d[p] = score_q[p];
      end
      if (state_q == JUDGE) begin
         if (right_q) begin
            score_d[player_q] = SCORE_W'(score_sat_add(int'(score_q[player_q]),
                                                       RIGHT_PTS, SCORE_MAX));
         end
`ifdef QUIZ_PENALTY_EN
         else begin
            score_d[player_q] = SCORE_W'(score_floor_sub(int'(score_q[player_q])));
         end
`else
`endif
      end
   end

   // State, countdown, verdict and registered outputs.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state_q      <= IDLE;
         countdown_q  <= 8'd0;
         player_q     <= 2'd0;
         right_q      <= 1'b0;
         sel_start_q  <= 1'b1;
         block_q      <= 1'b0;
         round_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         countdown_q  <= countdown_d;
         player_q     <= player_d;
         right_q      <= right_d;
         sel_start_q  <= (state_d == IDLE);
         block_q      <= (state_d == TIMEOUT);
         round_done_q <= (state_d == JUDGE) ||
                         (state_q == TIMEOUT && state_d == IDLE);
      end
   end

   // Score registers.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            score_q[p] <= '0;
         end
      end else begin
         for (int p = 0; p < NUM_PLAYERS; p++) begin
            score_q[p] <= score_d[p];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_pack
         assign scores_packed[gi*SCORE_W +: SCORE_W] = score_q[gi];
      end
   endgenerate

   assign bus.Sel_Start      = sel_start_q;
   assign bus.TimeOver_Block = block_q;
   assign bus.Countdown      = countdown_q;
   assign bus.State          = state_q;
   assign bus.Scores         = scores_packed;
   assign bus.Round_Done     = round_done_q;
endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: directed round scenarios plus random pulses,
// compared every cycle with a round-level reference model.
module tb_quiz_round_ctrl;
   import quiz_pkg::*;

   localparam int TICK_DIV  = 4;
   localparam int BUZZ_SEC  = 3;
   localparam int ANS_SEC   = 2;
   localparam int SCORE_W   = 4;
   localparam int RIGHT_PTS = 1;
   localparam int SMAX      = (1 << SCORE_W) - 1;

   logic CLK = 1'b0;
   logic RSTn = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   quiz_round_ctrl_if #(.SCORE_W(SCORE_W)) bus ();

   quiz_round_ctrl #(
      .TICK_DIV  (TICK_DIV),
      .BUZZ_SEC  (BUZZ_SEC),
      .ANS_SEC   (ANS_SEC),
      .SCORE_W   (SCORE_W),
      .RIGHT_PTS (RIGHT_PTS)
   ) dut (
      .CLK  (CLK),
      .RSTn (RSTn),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   // Reference model: phase, cycles spent in it, and what the display shows.
   state_t m_state;
   int     m_cnt;
   int     m_countdown;
   int     m_player;
   bit     m_right;
   bit     m_done;
   int     m_score [4];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = IDLE; m_cnt = 0; m_countdown = 0; m_player = 1;
      m_right = 0; m_done = 0;
      for (int p = 0; p < 4; p++) m_score[p] = 0;
   endtask

   // One clock of round rules; windows expire after win*TICK_DIV cycles.
   task automatic model_step(input bit hs, input bit jr, input bit jw,
                             input bit lk, input int pl);
      state_t nxt;
      int     left;
      nxt = m_state;
      case (m_state)
         IDLE: if (hs) begin nxt = ARMED; m_countdown = BUZZ_SEC; end
         ARMED: begin
            if (lk && pl >= 1 && pl <= 4) begin
               nxt = ANSWER; m_player = pl; m_countdown = ANS_SEC;
            end else begin
               left = BUZZ_SEC - (m_cnt + 1) / TICK_DIV;
               if (left <= 0) begin nxt = TIMEOUT; m_countdown = 0; end
               else m_countdown = left;
            end
         end
         ANSWER: begin
            if (jr || jw) begin
               nxt = JUDGE; m_right = jr;
            end else begin
               left = ANS_SEC - (m_cnt + 1) / TICK_DIV;
               if (left <= 0) begin nxt = JUDGE; m_right = 0; m_countdown = 0; end
               else m_countdown = left;
            end
         end
         JUDGE: begin
            nxt = IDLE;
            if (m_right) begin
               m_score[m_player-1] = m_score[m_player-1] + RIGHT_PTS;
               if (m_score[m_player-1] > SMAX) m_score[m_player-1] = SMAX;
            end else begin
`ifdef QUIZ_PENALTY_EN
               if (m_score[m_player-1] > 0) m_score[m_player-1] = m_score[m_player-1] - 1;
`endif
            end
         end
         TIMEOUT: if (hs) nxt = IDLE;
         default: nxt = IDLE;
      endcase
      m_done = (nxt == JUDGE) || (m_state == TIMEOUT && nxt == IDLE);
      m_cnt  = (nxt != m_state) ? 0 : m_cnt + 1;
      m_state = nxt;
   endtask

   task automatic check_all();
      logic [15:0] exp_scores;
      for (int p = 0; p < 4; p++) exp_scores[p*4 +: 4] = 4'(m_score[p]);
      check("state",      32'(bus.State),          32'(m_state));
      check("countdown",  32'(bus.Countdown),      32'(m_countdown));
      check("sel_start",  32'(bus.Sel_Start),      32'(m_state == IDLE));
      check("block",      32'(bus.TimeOver_Block), 32'(m_state == TIMEOUT));
      check("round_done", 32'(bus.Round_Done),     32'(m_done));
      check("scores",     32'(bus.Scores),         32'(exp_scores));
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_state"},     32'(bus.State),          32'(0));
      check({tag, "_countdown"}, 32'(bus.Countdown),      32'(0));
      check({tag, "_sel_start"}, 32'(bus.Sel_Start),      32'(1));
      check({tag, "_block"},     32'(bus.TimeOver_Block), 32'(0));
      check({tag, "_scores"},    32'(bus.Scores),         32'(0));
      check({tag, "_done"},      32'(bus.Round_Done),     32'(0));
   endtask

   // Drive one cycle of inputs, advance model, compare after the edge.
   task automatic apply(input bit hs, input bit jr, input bit jw,
                        input bit lk, input int pl);
      bus.Host_Start  = hs;
      bus.Judge_Right = jr;
      bus.Judge_Wrong = jw;
      bus.Sel_Locked  = lk;
      bus.Sel_Player  = 4'(pl);
      @(posedge CLK);
      model_step(hs, jr, jw, lk, pl);
      @(negedge CLK);
      check_all();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) apply(0, 0, 0, 0, 0);
   endtask

   task automatic round(input int pl, input bit jr, input bit jw);
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, pl);
      apply(0, jr, jw, 0, 0);
      apply(0, 0, 0, 0, 0);
   endtask

   initial begin
      bus.Host_Start = 0; bus.Judge_Right = 0; bus.Judge_Wrong = 0;
      bus.Sel_Locked = 0; bus.Sel_Player = 4'd0;
      model_reset();
      repeat (3) @(negedge CLK);
      check_reset_vals("reset");
      RSTn = 1'b1;
      @(negedge CLK);
      check_all();

      // Round start and first tick.
      apply(1, 0, 0, 0, 0);
      idle_cycles(4);
      // Player 2 locks and is judged right.
      apply(0, 0, 0, 1, 2);
      apply(0, 1, 0, 0, 0);
      idle_cycles(2);
      // Buzz-in timeout, then host closes the round.
      apply(1, 0, 0, 0, 0);
      idle_cycles(13);
      apply(1, 0, 0, 0, 0);
      idle_cycles(1);
      // Player 4 to 3 points, then answer timeout.
      for (int i = 0; i < 3; i++) round(4, 1, 0);
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, 4);
      idle_cycles(10);
      // Floor case: player 3 at zero times out.
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, 3);
      idle_cycles(10);
      // Invalid players and stray judge pulses are ignored.
      apply(0, 1, 1, 1, 0);
      apply(1, 0, 0, 1, 0);
      apply(0, 0, 0, 1, 5);
      apply(0, 1, 0, 1, 7);
      idle_cycles(12);
      apply(1, 0, 0, 0, 0);
      // Player 1 to saturation; both verdicts together count as right.
      for (int i = 0; i < 17; i++) round(1, 1, (i % 2) == 1);
      round(1, 1, 1);
      round(2, 0, 1);

      // Random pulses.
      for (int i = 0; i < 3000; i++) begin
         apply($urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
               $urandom_range(0, 11) == 0, $urandom_range(0, 6) == 0,
               int'($urandom_range(0, 7)));
      end

      // Asynchronous abort in ANSWER with nonzero scores.
      idle_cycles(20);
      apply(1, 0, 0, 0, 0);
      idle_cycles(20);
      round(3, 1, 0);
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, 3);
      check("answer_before_abort", 32'(bus.State), 32'(ANSWER));
      #2 RSTn = 1'b0;
      #1 check_reset_vals("async");
      model_reset();
      @(posedge CLK);
      @(negedge CLK);
      check_reset_vals("held");
      RSTn = 1'b1;
      apply(1, 0, 0, 0, 0);
      apply(0, 0, 0, 1, 2);
      apply(0, 1, 0, 0, 0);
      idle_cycles(3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/quiz_round_ctrl.md
Name: quiz_round_ctrl

Overview:
Round sequencer for the quiz responder. Drives the player-selection stage's round-release (Sel_Start) and buzz-in block (TimeOver_Block), and runs the buzz-in and answer countdowns from a 1 s tick. Collects the host verdict and keeps a saturating score per player. Sits between the host pushbuttons/display and the selection stage.

Parameters:
TICK_DIV, 50_000_000, clock cycles per countdown tick (1 s at 50 MHz)
BUZZ_SEC, 10, buzz-in window length in ticks
ANS_SEC, 5, answer window length in ticks after a player locks in
SCORE_W, 4, width of each player score
RIGHT_PTS, 1, points added on a correct verdict

Ports:
CLK  in  1  system clock
RSTn  in  1  asynchronous active-low reset
Host_Start  in  1  synchronous one-cycle pulse, begins a round
Judge_Right  in  1  one-cycle pulse, host marks answer correct
Judge_Wrong  in  1  one-cycle pulse, host marks answer wrong
Sel_Locked  in  1  selection stage has locked a player (its Timer_Start)
Sel_Player  in  4  locked player number, 1..4; 0 means none
Sel_Start  out  1  high holds the selection stage cleared; low lets it accept keys
TimeOver_Block  out  1  high blocks further buzz-ins
Countdown  out  8  ticks remaining in the current window
State  out  3  encoded FSM state, for the display
Scores  out  4*SCORE_W  packed scores; player 1 occupies the LSBs
Round_Done  out  1  one-cycle pulse when the round closes

Behaviour:
- Reset values: State=IDLE, Sel_Start=1, TimeOver_Block=0, Countdown=0, Scores=0, Round_Done=0, prescaler=0.
- Prescaler counts 0..TICK_DIV-1 and pulses tick on the wrap. It is cleared on every state change, so the first tick in a state comes exactly TICK_DIV cycles after entry.
- IDLE:
  - Sel_Start=1.
  - Host_Start -> ARMED next cycle; Countdown<=BUZZ_SEC.
- ARMED:
  - Sel_Start=0, TimeOver_Block=0.
  - Each tick decrements Countdown.
  - Sel_Locked with Sel_Player in 1..4 -> ANSWER; Countdown<=ANS_SEC. Lock takes priority over a same-cycle tick.
  - Countdown reaching 0 with no lock -> TIMEOUT.
- ANSWER:
  - Sel_Start=0; player identity is latched at entry.
  - Each tick decrements Countdown.
  - Judge_Right or Judge_Wrong -> JUDGE, recording the verdict. If both pulse in the same cycle, Right wins.
  - Countdown reaching 0 -> JUDGE with verdict "wrong".
- JUDGE (one cycle):
  - Right: latched player's score += RIGHT_PTS, saturating at 2^SCORE_W-1.
  - Wrong: score change per the optional feature.
  - -> IDLE; Round_Done=1 for that cycle.
- TIMEOUT:
  - TimeOver_Block=1, Sel_Start=0, Countdown=0.
  - Host_Start -> IDLE with Round_Done=1.
- General rules:
  - Host_Start in any state other than IDLE or TIMEOUT is ignored.
  - A Sel_Player of 0 or greater than 4 while Sel_Locked is high is ignored.
  - Judge pulses outside ANSWER are ignored.
  - Countdown never underflows; it holds at 0.
  - Asserting RSTn low mid-round aborts immediately to the reset values, including Scores.
- All outputs are registered.

Optional Feature:
- Macro: QUIZ_PENALTY_EN.
- Defined: a wrong verdict or answer timeout subtracts 1 from the latched player's score, with a floor of 0.
- Undefined: a wrong verdict or timeout leaves the score unchanged.

Decomposition:
- Package quiz_pkg holds:
  - the state enum (IDLE=0, ARMED=1, ANSWER=2, JUDGE=3, TIMEOUT=4);
  - NUM_PLAYERS=4;
  - the score saturate-add and floor-subtract helper functions.
- Sub-module quiz_tick_gen: TICK_DIV prescaler with a synchronous clear input and a one-cycle tick output.

Test Plan:
All scenarios use TICK_DIV=4, BUZZ_SEC=3, ANS_SEC=2, SCORE_W=4.
1. Reset, then Host_Start -> next cycle State=ARMED, Sel_Start=0, Countdown=3; after 4 cycles Countdown=2.
2. Sel_Locked with Sel_Player=2 in ARMED, then Judge_Right -> Scores[7:4]=1, Round_Done pulses once, State=IDLE, Sel_Start=1.
3. No lock for 12 cycles after ARMED entry -> State=TIMEOUT, TimeOver_Block=1; Host_Start -> IDLE, TimeOver_Block=0.
4. Player 4 locks, no verdict for 8 cycles -> JUDGE then IDLE.
   - With QUIZ_PENALTY_EN: player 4 score 3 -> 2.
   - Without it: score stays 3.
   - Floor check with QUIZ_PENALTY_EN: score 0 stays 0.
5. Player 1 at score 15 gets Judge_Right -> score stays 15.
   - Same cycle as any case: Judge_Right and Judge_Wrong together are scored as Right.
6. RSTn pulled low during ANSWER with Scores nonzero -> all outputs return to reset values asynchronously; Scores=0.
